// File: rtl/weight_load_ctrl.sv
// rtl/weight_load_ctrl.sv - weight tile fetch into column shifters and skewed drain into the array
module weight_load_ctrl #(
   parameter int ARRAYHEIGHT = 4,
   parameter int ARRAYWIDTH  = 4,
   parameter int DATASIZE    = 8,
   parameter int ADDRW       = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDRW-1:0]      base_addr,
   input  logic                  drain_go,
   output logic                  busy,
   output logic                  done,
   output logic                  buf_rd_en,
   output logic [ADDRW-1:0]      buf_rd_addr,
   input  logic [DATASIZE-1:0]   buf_rd_data,
   output logic [DATASIZE-1:0]   col_in_data,
   output logic [ARRAYWIDTH-1:0] col_load_en,
   output logic [ARRAYWIDTH-1:0] col_out_en
);

   localparam int NWORDS = ARRAYHEIGHT * ARRAYWIDTH;
   localparam int NDRAIN = ARRAYHEIGHT + ARRAYWIDTH - 1;
   localparam int LCW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam int DCW    = (NDRAIN > 1) ? $clog2(NDRAIN) : 1;
   localparam logic [LCW-1:0] LOAD_LAST  = LCW'(NWORDS - 1);
   localparam logic [DCW-1:0] DRAIN_LAST = DCW'(NDRAIN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_FLUSH,
      S_WAIT,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [ADDRW-1:0]      base_q, base_d;
   logic [LCW-1:0]        ld_cnt_q, ld_cnt_d;
   logic [DCW-1:0]        dr_cnt_q, dr_cnt_d;
   logic [ARRAYWIDTH-1:0] col_load_q, col_load_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         base_q     <= '0;
         ld_cnt_q   <= '0;
         dr_cnt_q   <= '0;
         col_load_q <= '0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         ld_cnt_q   <= ld_cnt_d;
         dr_cnt_q   <= dr_cnt_d;
         col_load_q <= col_load_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      ld_cnt_d    = ld_cnt_q;
      dr_cnt_d    = dr_cnt_q;
      col_load_d  = '0;
      busy        = 1'b1;
      done        = 1'b0;
      buf_rd_en   = 1'b0;
      buf_rd_addr = '0;
      unique case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               base_d   = base_addr;
               ld_cnt_d = '0;
               state_d  = S_LOAD;
            end
         end
         S_LOAD: begin
            buf_rd_en   = 1'b1;
            buf_rd_addr = base_q + ADDRW'(ld_cnt_q);
            // column select for the word returning next cycle: k / H
            col_load_d  = ARRAYWIDTH'(1) << (int'(ld_cnt_q) / ARRAYHEIGHT);
            if (ld_cnt_q == LOAD_LAST) begin
               ld_cnt_d = '0;
               state_d  = S_FLUSH;
            end else begin
               ld_cnt_d = ld_cnt_q + 1'b1;
            end
         end
         S_FLUSH: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (drain_go) begin
               dr_cnt_d = '0;
               state_d  = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (dr_cnt_q == DRAIN_LAST) begin
               dr_cnt_d = '0;
               state_d  = S_DONE;
            end else begin
               dr_cnt_d = dr_cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // column c drains during t = c .. c+H-1, giving the one-cycle skew per column
   always_comb begin
      col_out_en = '0;
      for (int c = 0; c < ARRAYWIDTH; c++) begin
         col_out_en[c] = (state_q == S_DRAIN) &&
                         (int'(dr_cnt_q) >= c) &&
                         (int'(dr_cnt_q) < c + ARRAYHEIGHT);
      end
   end

   // buffer data already arrives one cycle after the read, aligned with the registered enable
   assign col_load_en = col_load_q;
   assign col_in_data = (|col_load_q) ? buf_rd_data : '0;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// tb/tb_weight_load_ctrl.sv - scoreboard bench for weight_load_ctrl with buffer and shifter models
module tb_weight_load_ctrl;

   localparam int H  = 4;
   localparam int W  = 4;
   localparam int DW = 8;
   localparam int AW = 16;
   localparam logic [3:0] DRAIN_PAT [7] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                            4'b1110, 4'b1100, 4'b1000};

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          drain_go = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic          busy, done, buf_rd_en;
   logic [AW-1:0] buf_rd_addr;
   logic [DW-1:0] buf_rd_data = '0;
   logic [DW-1:0] col_in_data;
   logic [W-1:0]  col_load_en, col_out_en;

   typedef struct packed {
      logic [31:0] cyc;
      logic [39:0] val;
   } exp_t;

   exp_t        rd_q[$], ld_q[$], out_q[$], done_q[$];
   logic [7:0]  shf [W][H];
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          done_seen = 0;

   weight_load_ctrl #(
      .ARRAYHEIGHT(H), .ARRAYWIDTH(W), .DATASIZE(DW), .ADDRW(AW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .drain_go(drain_go), .busy(busy), .done(done), .buf_rd_en(buf_rd_en),
      .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
      .col_in_data(col_in_data), .col_load_en(col_load_en), .col_out_en(col_out_en)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // weight buffer: mem[a] = a[7:0], one-cycle read latency
   always @(posedge clk) if (buf_rd_en) buf_rd_data <= buf_rd_addr[7:0];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h (cyc %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name, input logic [79:0] got);
      checks++;
      errors++;
      $display("FAIL %s: got unexpected output %h, required none (cyc %0d)", name, got, cyc);
   endtask

   task automatic push_exp(input int which, input int unsigned c, input logic [39:0] v);
      exp_t e;
      e.cyc = c;
      e.val = v;
      case (which)
         0:       rd_q.push_back(e);
         1:       ld_q.push_back(e);
         2:       out_q.push_back(e);
         default: done_q.push_back(e);
      endcase
   endtask

   // drain granted in the cycle whose cyc value is g: DRAIN occupies g+1 .. g+7, done at g+8
   task automatic push_drain(input logic [15:0] b, input int unsigned g);
      for (int t = 0; t < 7; t++) begin
         logic [31:0] d;
         logic [15:0] a;
         d = '0;
         for (int c = 0; c < W; c++) begin
            if (DRAIN_PAT[t][c]) begin
               a = b + 16'(c * H + (H - 1) - (t - c));
               d[c*8 +: 8] = a[7:0];
            end
         end
         push_exp(2, g + 1 + 32'(t), 40'({DRAIN_PAT[t], d}));
      end
      push_exp(3, g + 8, 40'd1);
   endtask

   task automatic start_tile(input logic [15:0] b, input bit grant_now, output int unsigned c0);
      c0 = cyc;
      for (int k = 0; k < H * W; k++) begin
         logic [15:0] a;
         a = b + 16'(k);
         push_exp(0, c0 + 1 + 32'(k), 40'(a));
         push_exp(1, c0 + 2 + 32'(k), 40'({4'(1 << (k / H)), a[7:0]}));
      end
      if (grant_now) push_drain(b, c0 + 18);
      base_addr = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".busy"},        80'(busy),        80'(0));
      check({tag, ".done"},        80'(done),        80'(0));
      check({tag, ".buf_rd_en"},   80'(buf_rd_en),   80'(0));
      check({tag, ".buf_rd_addr"}, 80'(buf_rd_addr), 80'(0));
      check({tag, ".col_in_data"}, 80'(col_in_data), 80'(0));
      check({tag, ".col_load_en"}, 80'(col_load_en), 80'(0));
      check({tag, ".col_out_en"},  80'(col_out_en),  80'(0));
   endtask

   task automatic wait_drained(input string tag);
      int n;
      n = 0;
      while ((rd_q.size() + ld_q.size() + out_q.size() + done_q.size()) != 0 && n < 80) begin
         @(negedge clk);
         n++;
      end
      check({tag, ".pending"}, 80'(rd_q.size() + ld_q.size() + out_q.size() + done_q.size()), 80'(0));
      repeat (3) @(negedge clk);
      check({tag, ".idle_busy"}, 80'(busy), 80'(0));
   endtask

   // monitor: pops the scoreboard whenever the DUT presents an output
   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] d;
      if (rst_n) begin
         if (buf_rd_en) begin
            if (rd_q.size() == 0) unexpected("read", 80'(buf_rd_addr));
            else begin
               e = rd_q.pop_front();
               check("read", {cyc, 40'(buf_rd_addr)}, 80'(e));
            end
         end
         if (col_load_en != '0) begin
            for (int c = 0; c < W; c++) begin
               if (col_load_en[c]) begin
                  for (int i = H - 1; i > 0; i--) shf[c][i] = shf[c][i-1];
                  shf[c][0] = col_in_data;
               end
            end
            if (ld_q.size() == 0) unexpected("load", 80'({col_load_en, col_in_data}));
            else begin
               e = ld_q.pop_front();
               check("load", {cyc, 40'({col_load_en, col_in_data})}, 80'(e));
            end
         end
         if (col_out_en != '0) begin
            d = '0;
            for (int c = 0; c < W; c++) begin
               if (col_out_en[c]) begin
                  d[c*8 +: 8] = shf[c][0];
                  for (int i = 0; i < H - 1; i++) shf[c][i] = shf[c][i+1];
                  shf[c][H-1] = '0;
               end
            end
            if (out_q.size() == 0) unexpected("drain", 80'({col_out_en, d}));
            else begin
               e = out_q.pop_front();
               check("drain", {cyc, 40'({col_out_en, d})}, 80'(e));
            end
         end
         if (done) begin
            done_seen++;
            if (done_q.size() == 0) unexpected("done", 80'(1));
            else begin
               e = done_q.pop_front();
               check("done", {cyc, 40'd1}, 80'(e));
            end
         end
         if (col_load_en != '0 || col_out_en != '0)
            check("exclusive", 80'({(col_load_en != '0) && (col_out_en != '0),
                                    $countones(col_load_en) > 1}), 80'(0));
      end
   end

   initial begin
      int unsigned c0;
      int          n0;
      for (int c = 0; c < W; c++) for (int i = 0; i < H; i++) shf[c][i] = '0;

      repeat (2) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // basic tile with immediate grant; start during LOAD and during DONE must be ignored
      drain_go = 1'b1;
      start_tile(16'h0010, 1'b1, c0);
      repeat (3) @(negedge clk);
      base_addr = 16'h0099;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (cyc < c0 + 26) @(negedge clk);
      check("done_cycle_busy", 80'(busy), 80'(1));
      base_addr = 16'h00AA;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_drained("tile_0010");

      // delayed grant, then drain_go dropped mid-drain
      drain_go = 1'b0;
      start_tile(16'h0020, 1'b0, c0);
      while (cyc < c0 + 18) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         check("wait.busy", 80'(busy), 80'(1));
         check("wait.enables", 80'({buf_rd_en, col_load_en, col_out_en}), 80'(0));
         if (i < 9) @(negedge clk);
      end
      drain_go = 1'b1;
      push_drain(16'h0020, cyc);
      repeat (2) @(negedge clk);
      drain_go = 1'b0;
      wait_drained("tile_0020");

      // address wrap
      drain_go = 1'b1;
      start_tile(16'hFFF8, 1'b1, c0);
      wait_drained("tile_fff8");

      // asynchronous reset in the middle of read k=6
      start_tile(16'h0030, 1'b1, c0);
      repeat (6) @(negedge clk);
      check("midload.pre_rd_en", 80'(buf_rd_en), 80'(1));
      #2 rst_n = 1'b0;
      #1 check_zero("midload");
      rd_q.delete();
      ld_q.delete();
      out_q.delete();
      done_q.delete();
      for (int c = 0; c < W; c++) for (int i = 0; i < H; i++) shf[c][i] = '0;
      n0 = done_seen;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("abort.no_done", 80'(done_seen), 80'(n0));
      check("abort.busy", 80'(busy), 80'(0));
      start_tile(16'h0040, 1'b1, c0);
      wait_drained("tile_0040");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
